// File: rtl/mig_app_responder.sv
// Behavioural stand-in for a MIG 7-series user interface (4:1, BL8): queued commands and
// write beats, on-chip RAM, fixed read latency. Define MIG_RESP_STALL_EN for LFSR back-pressure.
module mig_app_responder #(
    parameter int MEM_DATA_BITS    = 64,
    parameter int MEM_IF_ADDR_BITS = 27,
    parameter int DEPTH_BITS       = 10,
    parameter int RD_LATENCY       = 4,
    parameter int CALIB_CYCLES     = 16,
    parameter int FIFO_BITS        = 4
) (
    input  logic                          mem_clk,
    input  logic                          rst,
    input  logic [MEM_IF_ADDR_BITS-1:0]   app_addr,
    input  logic [2:0]                    app_cmd,
    input  logic                          app_en,
    output logic                          app_rdy,
    input  logic [MEM_DATA_BITS-1:0]      app_wdf_data,
    input  logic [MEM_DATA_BITS/8-1:0]    app_wdf_mask,
    input  logic                          app_wdf_wren,
    input  logic                          app_wdf_end,
    output logic                          app_wdf_rdy,
    output logic [MEM_DATA_BITS-1:0]      app_rd_data,
    output logic                          app_rd_data_valid,
    output logic                          app_rd_data_end,
    output logic                          init_calib_complete,
    output logic                          ui_clk_sync_rst,
    output logic                          cmd_err
);

    localparam int MASK_BITS  = MEM_DATA_BITS / 8;
    localparam int FIFO_DEPTH = 1 << FIFO_BITS;
    localparam int WORDS      = 1 << DEPTH_BITS;
    localparam int CAL_W      = $clog2(CALIB_CYCLES + 1);
    localparam int CMD_W      = 3 + DEPTH_BITS;
    localparam int WDF_W      = MEM_DATA_BITS + MASK_BITS;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // ---------------- calibration and UI reset ----------------
    logic [CAL_W-1:0] cal_cnt_q;
    logic             calib_q;
    logic [2:0]       srst_cnt_q;
    logic             srst_q;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            cal_cnt_q  <= '0;
            calib_q    <= 1'b0;
            srst_cnt_q <= '0;
            srst_q     <= 1'b1;
        end else begin
            if (!calib_q) begin
                cal_cnt_q <= cal_cnt_q + 1'b1;
                if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
            end
            if (srst_q) begin
                srst_cnt_q <= srst_cnt_q + 1'b1;
                if (srst_cnt_q == 3'd3) srst_q <= 1'b0;
            end
        end
    end

    // ---------------- optional back-pressure ----------------
    logic stall_cmd;
    logic stall_wdf;
`ifdef MIG_RESP_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge mem_clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall_cmd = (lfsr_q[1:0] == 2'b00);
    assign stall_wdf = (lfsr_q[3:2] == 2'b00);
`else
    assign stall_cmd = 1'b0;
    assign stall_wdf = 1'b0;
`endif

    // ---------------- command and write-data FIFOs ----------------
    logic [CMD_W-1:0]   cmd_mem [FIFO_DEPTH];
    logic [WDF_W-1:0]   wdf_mem [FIFO_DEPTH];
    logic [FIFO_BITS:0] cmd_wp_q, cmd_rp_q, wdf_wp_q, wdf_rp_q;
    logic cmd_empty, cmd_full, wdf_empty, wdf_full;
    logic cmd_push, cmd_pop, wdf_push, wdf_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign cmd_empty = (cmd_wp_q == cmd_rp_q);
    assign cmd_full  = (cmd_wp_q[FIFO_BITS] != cmd_rp_q[FIFO_BITS]) &&
                       (cmd_wp_q[FIFO_BITS-1:0] == cmd_rp_q[FIFO_BITS-1:0]);
    assign wdf_empty = (wdf_wp_q == wdf_rp_q);
    assign wdf_full  = (wdf_wp_q[FIFO_BITS] != wdf_rp_q[FIFO_BITS]) &&
                       (wdf_wp_q[FIFO_BITS-1:0] == wdf_rp_q[FIFO_BITS-1:0]);

    assign app_rdy     = calib_q & ~cmd_full & ~stall_cmd;
    assign app_wdf_rdy = calib_q & ~wdf_full & ~stall_wdf;
    assign cmd_push    = app_en & app_rdy;
    assign wdf_push    = app_wdf_wren & app_wdf_rdy;

    always_ff @(posedge mem_clk) begin
        if (cmd_push) cmd_mem[cmd_wp_q[FIFO_BITS-1:0]] <= {app_cmd, app_addr[DEPTH_BITS+2:3]};
        if (wdf_push) wdf_mem[wdf_wp_q[FIFO_BITS-1:0]] <= {app_wdf_mask, app_wdf_data};
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            cmd_wp_q <= '0;
            cmd_rp_q <= '0;
            wdf_wp_q <= '0;
            wdf_rp_q <= '0;
        end else begin
            if (cmd_push) cmd_wp_q <= cmd_wp_q + 1'b1;
            if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 1'b1;
            if (wdf_push) wdf_wp_q <= wdf_wp_q + 1'b1;
            if (wdf_pop)  wdf_rp_q <= wdf_rp_q + 1'b1;
        end
    end

    // ---------------- executor: one command per cycle, in order ----------------
    logic [2:0]            head_cmd;
    logic [DEPTH_BITS-1:0] head_idx;
    logic [MEM_DATA_BITS-1:0] wd_data;
    logic [MASK_BITS-1:0]     wd_mask;
    logic do_write, do_read, bad_cmd;

    assign {head_cmd, head_idx} = cmd_mem[cmd_rp_q[FIFO_BITS-1:0]];
    assign {wd_mask, wd_data}   = wdf_mem[wdf_rp_q[FIFO_BITS-1:0]];

    always_comb begin
        cmd_pop  = 1'b0;
        wdf_pop  = 1'b0;
        do_write = 1'b0;
        do_read  = 1'b0;
        bad_cmd  = 1'b0;
        if (!rst && !cmd_empty) begin
            case (head_cmd)
                CMD_WRITE: begin
                    // A write at the head holds the queue until its beat arrives.
                    if (!wdf_empty) begin
                        cmd_pop  = 1'b1;
                        wdf_pop  = 1'b1;
                        do_write = 1'b1;
                    end
                end
                CMD_READ: begin
                    cmd_pop = 1'b1;
                    do_read = 1'b1;
                end
                default: begin
                    cmd_pop = 1'b1;
                    bad_cmd = 1'b1;
                end
            endcase
        end
    end

    logic cmd_err_q;
    always_ff @(posedge mem_clk) begin
        if (rst)          cmd_err_q <= 1'b0;
        else if (bad_cmd) cmd_err_q <= 1'b1;
    end

    // ---------------- backing RAM and read pipe ----------------
    logic [MEM_DATA_BITS-1:0] ram [WORDS];
    logic [MEM_DATA_BITS-1:0] ram_rd_q;

    always_ff @(posedge mem_clk) begin
        if (do_write) begin
            for (int b = 0; b < MASK_BITS; b++) begin
                if (!wd_mask[b]) ram[head_idx][8*b +: 8] <= wd_data[8*b +: 8];
            end
        end
        ram_rd_q <= ram[head_idx];
    end

    // Stage 0 is the RAM output register; stage RD_LATENCY drives the port.
    logic [RD_LATENCY:0]      rd_vld_q;
    logic [MEM_DATA_BITS-1:0] rd_dat_q [1:RD_LATENCY];

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            rd_vld_q <= '0;
            for (int i = 1; i <= RD_LATENCY; i++) rd_dat_q[i] <= '0;
        end else begin
            rd_vld_q    <= {rd_vld_q[RD_LATENCY-1:0], do_read};
            rd_dat_q[1] <= ram_rd_q;
            for (int i = 2; i <= RD_LATENCY; i++) rd_dat_q[i] <= rd_dat_q[i-1];
        end
    end

    assign app_rd_data         = rd_dat_q[RD_LATENCY];
    assign app_rd_data_valid   = rd_vld_q[RD_LATENCY];
    assign app_rd_data_end     = rd_vld_q[RD_LATENCY];
    assign init_calib_complete = calib_q;
    assign ui_clk_sync_rst     = srst_q;
    assign cmd_err             = cmd_err_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, app_wdf_end, app_addr};

endmodule

// File: tb/tb_mig_app_responder.sv
// Self-checking bench for mig_app_responder: directed scenarios plus randomized traffic,
// scored against an in-order command/beat queue model of the memory.
module tb_mig_app_responder;

  localparam int DW = 64;
  localparam int AW = 27;
  localparam int DB = 10;
  localparam int NOPS = 150;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [7:0]    app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;
  logic          ui_clk_sync_rst;
  logic          cmd_err;

  mig_app_responder dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .cmd_err             (cmd_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 mem_clk = ~mem_clk;

  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [1024];
  logic [2:0]    m_cmd_q[$];
  int            m_idx_q[$];
  logic [DW-1:0] m_dat_q[$];
  logic [7:0]    m_msk_q[$];

  function automatic int word_of(input logic [AW-1:0] a);
    int x;
    x = int'(a);
    return (x / 8) % (1 << DB);
  endfunction

  // Commands retire strictly in arrival order; a write needs the oldest unused beat.
  function automatic void model_drain();
    logic [DW-1:0] d;
    logic [7:0] m;
    int idx;
    bit stop;
    stop = 0;
    while (m_cmd_q.size() > 0 && !stop) begin
      idx = m_idx_q[0];
      if (m_cmd_q[0] == 3'b000) begin
        if (m_dat_q.size() == 0) begin
          stop = 1;
        end else begin
          d = m_dat_q.pop_front();
          m = m_msk_q.pop_front();
          for (int b = 0; b < 8; b++)
            if (!m[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
          void'(m_cmd_q.pop_front());
          void'(m_idx_q.pop_front());
        end
      end else begin
        if (m_cmd_q[0] == 3'b001) exp_q.push_back(model_mem[idx]);
        void'(m_cmd_q.pop_front());
        void'(m_idx_q.pop_front());
      end
    end
  endfunction

  function automatic void model_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    m_cmd_q.push_back(c);
    m_idx_q.push_back(word_of(a));
    model_drain();
  endfunction

  function automatic void model_beat(input logic [DW-1:0] d, input logic [7:0] m);
    m_dat_q.push_back(d);
    m_msk_q.push_back(m);
    model_drain();
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_cmd_q.delete();
    m_idx_q.delete();
    m_dat_q.delete();
    m_msk_q.delete();
  endfunction

  // ---------------- scoreboard monitor ----------------
  int beat_count = 0;
  int last_beat_cyc = 0;
  logic [DW-1:0] last_beat_data = '0;
  int beat_cyc_q[$];
  logic [DW-1:0] exp_v;

  always @(negedge mem_clk) begin
    if (!rst) begin
      if (app_rd_data_valid) begin
        beat_count++;
        last_beat_cyc = cyc;
        last_beat_data = app_rd_data;
        beat_cyc_q.push_back(cyc);
        checks++;
        if (app_rd_data_end !== 1'b1) begin
          errors++;
          $display("FAIL rd_end: got %b want 1 at cycle %0d", app_rd_data_end, cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got beat %h want no beat at cycle %0d", app_rd_data, cyc);
        end else begin
          exp_v = exp_q.pop_front();
          if (app_rd_data !== exp_v) begin
            errors++;
            $display("FAIL rd_data: got %h want %h at cycle %0d", app_rd_data, exp_v, cyc);
          end
        end
      end else if (app_rd_data_end !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rd_end_idle: got %b want 0 at cycle %0d", app_rd_data_end, cyc);
      end
    end
  end

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  int acc_cyc = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mem_clk);
      #1;
    end
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    int n;
    bit done;
    logic r;
    n = 0;
    done = 0;
    r = 0;
    app_cmd = c;
    app_addr = a;
    app_en = 1'b1;
    while (!done) begin
      @(negedge mem_clk);
      r = app_rdy;
      @(posedge mem_clk);
      #1;
      if (r) begin
        done = 1;
      end else begin
        n++;
        if (n > 2000) begin
          checks++;
          errors++;
          $display("FAIL cmd_timeout: got no app_rdy in %0d cycles want accept", n);
          done = 1;
        end
      end
    end
    app_en = 1'b0;
    if (r) begin
      acc_cyc = cyc;
      model_cmd(c, a);
    end
  endtask

  task automatic do_beat(input logic [DW-1:0] d, input logic [7:0] m);
    int n;
    bit done;
    logic r;
    n = 0;
    done = 0;
    r = 0;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    while (!done) begin
      @(negedge mem_clk);
      r = app_wdf_rdy;
      @(posedge mem_clk);
      #1;
      if (r) begin
        done = 1;
      end else begin
        n++;
        if (n > 2000) begin
          checks++;
          errors++;
          $display("FAIL wdf_timeout: got no app_wdf_rdy in %0d cycles want accept", n);
          done = 1;
        end
      end
    end
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
    if (r) model_beat(d, m);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_cmd_q.size() != 0) && n < 3000) begin
      @(posedge mem_clk);
      n++;
    end
    #1;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending reads want 0", exp_q.size());
    end
    tick(4);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int w;
    w = $urandom_range(0, 63) * 8 + $urandom_range(0, 7) + ($urandom_range(0, 3) << 13);
    return AW'(w);
  endfunction

  function automatic logic [7:0] rand_mask();
    if ($urandom_range(0, 1) == 1) return 8'h00;
    return 8'($urandom);
  endfunction

  // ---------------- main sequence ----------------
  logic [2:0]    op_cmd [NOPS];
  logic [AW-1:0] op_addr [NOPS];
  logic [AW-1:0] full_addr [16];

  initial begin
    int rise;
    int fall;
    int nw;
    int n;
    int beats_before;
    int t;
    bit rdy_early;

    app_en = 0;
    app_cmd = 0;
    app_addr = 0;
    app_wdf_data = 0;
    app_wdf_mask = 0;
    app_wdf_wren = 0;
    app_wdf_end = 0;
    rst = 1;

    // Reset values and calibration timing
    tick(5);
    check("rst_sync_rst", ui_clk_sync_rst, 1);
    check("rst_calib", init_calib_complete, 0);
    check("rst_app_rdy", app_rdy, 0);
    check("rst_wdf_rdy", app_wdf_rdy, 0);
    check("rst_rd_valid", app_rd_data_valid, 0);
    check("rst_cmd_err", cmd_err, 0);
    rst = 0;
    rise = 0;
    fall = 0;
    rdy_early = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (!init_calib_complete && (app_rdy || app_wdf_rdy)) rdy_early = 1;
      if (rise == 0 && init_calib_complete) rise = i;
      if (fall == 0 && !ui_clk_sync_rst) fall = i;
    end
    check("calib_rise_cycles", rise, 16);
    check("sync_rst_fall_cycles", fall, 4);
    check("ready_before_calib", rdy_early, 0);

    // Give the 64 words used by the bench a known value
    for (int w = 0; w < 64; w++) begin
      do_cmd(3'b000, AW'(w * 8));
      do_beat({$urandom, $urandom}, 8'h00);
    end
    wait_drain();

    // Write then read one word; latency from read accept
    do_cmd(3'b000, AW'('h10));
    do_beat(64'hA5A5_0123_4567_89AB, 8'h00);
    do_cmd(3'b001, AW'('h10));
    t = acc_cyc;
    wait_drain();
    check("rd_latency", last_beat_cyc - t, 5);
    check("rd_first_data", last_beat_data, 64'hA5A5_0123_4567_89AB);

    // Beats ahead of commands, then back-to-back reads
    do_beat(64'd1, 8'h00);
    do_beat(64'd2, 8'h00);
    do_beat(64'd3, 8'h00);
    do_cmd(3'b000, AW'(0));
    do_cmd(3'b000, AW'(8));
    do_cmd(3'b000, AW'(16));
    beat_cyc_q.delete();
    do_cmd(3'b001, AW'(0));
    do_cmd(3'b001, AW'(8));
    do_cmd(3'b001, AW'(16));
    wait_drain();
    check("b2b_count", beat_cyc_q.size(), 3);
    if (beat_cyc_q.size() >= 3) begin
      check("b2b_gap1", beat_cyc_q[1] - beat_cyc_q[0], 1);
      check("b2b_gap2", beat_cyc_q[2] - beat_cyc_q[1], 1);
    end

    // Byte masking and address wrap
    do_cmd(3'b000, AW'(0));
    do_beat('1, 8'h00);
    do_cmd(3'b000, AW'(0));
    do_beat('0, 8'h0F);
    do_cmd(3'b001, AW'(0));
    do_cmd(3'b001, AW'(8 << DB));
    wait_drain();
    check("mask_wrap_data", last_beat_data, 64'h0000_0000_FFFF_FFFF);

    // Fill the command queue with data-less writes
    for (int i = 0; i < 16; i++) begin
      full_addr[i] = rand_addr();
      do_cmd(3'b000, full_addr[i]);
    end
    check("full_rdy_low", app_rdy, 0);
    tick(3);
    check("full_rdy_held", app_rdy, 0);
    for (int i = 0; i < 16; i++) do_beat({$urandom, $urandom}, rand_mask());
    n = 0;
    while (!app_rdy && n < 100) begin
      tick(1);
      n++;
    end
    check("full_rdy_return", app_rdy, 1);
    for (int i = 0; i < 16; i++) do_cmd(3'b001, full_addr[i]);
    wait_drain();

    // Randomized traffic; commands and beats driven independently
    nw = 0;
    for (int i = 0; i < NOPS; i++) begin
      op_cmd[i] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b000;
      op_addr[i] = rand_addr();
      if (op_cmd[i] == 3'b000) nw++;
    end
    fork
      begin
        for (int i = 0; i < NOPS; i++) begin
          do_cmd(op_cmd[i], op_addr[i]);
          tick($urandom_range(0, 2));
        end
      end
      begin
        for (int j = 0; j < nw; j++) begin
          do_beat({$urandom, $urandom}, rand_mask());
          tick($urandom_range(0, 3));
        end
      end
    join
    wait_drain();

    // Illegal command: sticky error, no beat, legal traffic still works
    beats_before = beat_count;
    do_cmd(3'b011, AW'('h40));
    tick(10);
    check("cmd_err_set", cmd_err, 1);
    check("bad_cmd_no_beat", beat_count - beats_before, 0);
    do_cmd(3'b000, AW'('h48));
    do_beat({$urandom, $urandom}, 8'h00);
    do_cmd(3'b001, AW'('h48));
    wait_drain();
    check("cmd_err_sticky", cmd_err, 1);

    // Reset with reads in flight: aborted, error cleared, RAM retained
    do_cmd(3'b001, AW'('h48));
    do_cmd(3'b001, AW'('h50));
    do_cmd(3'b001, AW'('h58));
    rst = 1;
    model_reset();
    beats_before = beat_count;
    tick(3);
    check("rst2_cmd_err", cmd_err, 0);
    check("rst2_rd_valid", app_rd_data_valid, 0);
    check("rst2_sync_rst", ui_clk_sync_rst, 1);
    rst = 0;
    n = 0;
    while (!init_calib_complete && n < 40) begin
      tick(1);
      n++;
    end
    check("recalib", init_calib_complete, 1);
    tick(8);
    check("rst_no_beats", beat_count - beats_before, 0);
    do_cmd(3'b001, AW'('h48));
    do_cmd(3'b001, AW'('h10));
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
